// File: rtl/calc_key_ctrl.sv
// Keypad/entry controller for the LCD calculator: 4x4 key-grid cursor, 16-char
// input string and a left-to-right, one-char-per-cycle expression evaluator.
module calc_key_ctrl #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned RES_W   = 24
) (
  input  logic                   clk_in,
  input  logic                   sys_rst,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_ok,
  output logic [3:0]             cursor_x,
  output logic [3:0]             cursor_y,
  output logic [MAX_LEN*8-1:0]   disp_str_flat,
  output logic [RES_W-1:0]       result,
  output logic                   calc_done,
  output logic                   busy
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  BLANK = 8'h20;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t             state;
  logic [1:0]         cx;
  logic [1:0]         cy;
  logic [7:0]         chars [MAX_LEN];
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   idx;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   num;
  logic [7:0]         op;

  logic [7:0]         key_c;
  logic               key_is_digit_c;
  logic [7:0]         cur_ch_c;
  logic               cur_is_digit_c;
  logic               full_c;
  logic [LEN_W-1:0]   len_m1_c;

  function automatic logic [RES_W-1:0] apply_op(input logic [7:0] o,
                                                  input logic [RES_W-1:0] a,
                                                  input logic [RES_W-1:0] b);
    case (o)
      "-":     apply_op = a - b;
      "*":     apply_op = a * b;
      default: apply_op = a + b;
    endcase
  endfunction

  // Key legend under the cursor, rows top to bottom
  always_comb begin
    key_c = BLANK;
    case ({cy, cx})
      4'h0: key_c = "1";  4'h1: key_c = "2";  4'h2: key_c = "3";  4'h3: key_c = "+";
      4'h4: key_c = "4";  4'h5: key_c = "5";  4'h6: key_c = "6";  4'h7: key_c = "-";
      4'h8: key_c = "7";  4'h9: key_c = "8";  4'hA: key_c = "9";  4'hB: key_c = "*";
      4'hC: key_c = "C";  4'hD: key_c = "0";  4'hE: key_c = "=";  4'hF: key_c = "B";
      default: key_c = BLANK;
    endcase
  end

  always_comb begin
    key_is_digit_c = (key_c >= "0") && (key_c <= "9");
    cur_ch_c       = chars[idx[IDX_W-1:0]];
    cur_is_digit_c = (cur_ch_c >= "0") && (cur_ch_c <= "9");
    full_c         = (len == LEN_W'(MAX_LEN));
    len_m1_c       = len - LEN_W'(1);
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign disp_str_flat[g*8 +: 8] = chars[g];
  end

  assign cursor_x = {2'b00, cx};
  assign cursor_y = {2'b00, cy};

  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cx        <= 2'd0;
      cy        <= 2'd0;
      for (int k = 0; k < MAX_LEN; k++) chars[k] <= BLANK;
      len       <= '0;
      idx       <= '0;
      acc       <= '0;
      num       <= '0;
      op        <= "+";
      result    <= '0;
      calc_done <= 1'b0;
      busy      <= 1'b0;
    end else if (state == EVAL) begin
      // Buttons are ignored; consume one character per cycle
      if (idx == len) begin
        result    <= apply_op(op, acc, num);
        busy      <= 1'b0;
        calc_done <= 1'b1;
        state     <= DONE;
      end else begin
        if (cur_is_digit_c) begin
          num <= num * RES_W'(10) + RES_W'(cur_ch_c - 8'h30);
        end else begin
          acc <= apply_op(op, acc, num);
          op  <= cur_ch_c;
          num <= '0;
        end
        idx <= idx + LEN_W'(1);
      end
    end else if (btn_ok) begin
      case (key_c)
        "+", "-", "*": begin
          calc_done <= 1'b0;
          state     <= IDLE;
          if (!full_c) begin
            chars[len[IDX_W-1:0]] <= key_c;
            len <= len + LEN_W'(1);
          end
        end
        "C": begin
          for (int k = 0; k < MAX_LEN; k++) chars[k] <= BLANK;
          len       <= '0;
          result    <= '0;
          calc_done <= 1'b0;
          state     <= IDLE;
        end
        "B": begin
          if (len != '0) begin
            chars[len_m1_c[IDX_W-1:0]] <= BLANK;
            len       <= len_m1_c;
            calc_done <= 1'b0;
            state     <= IDLE;
          end
        end
        "=": begin
          calc_done <= 1'b0;
          busy      <= 1'b1;
          idx       <= '0;
          acc       <= '0;
          num       <= '0;
          op        <= "+";
          state     <= EVAL;
        end
        default: begin
          if (key_is_digit_c) begin
            calc_done <= 1'b0;
            state     <= IDLE;
            // A digit after a result starts a fresh expression
            if (state == DONE) begin
              for (int k = 0; k < MAX_LEN; k++) chars[k] <= BLANK;
              chars[0] <= key_c;
              len      <= LEN_W'(1);
            end else if (!full_c) begin
              chars[len[IDX_W-1:0]] <= key_c;
              len <= len + LEN_W'(1);
            end
          end
        end
      endcase
    end else if (btn_up) begin
      cy <= cy - 2'd1;
    end else if (btn_down) begin
      cy <= cy + 2'd1;
    end else if (btn_left) begin
      cx <= cx - 2'd1;
    end else if (btn_right) begin
      cx <= cx + 2'd1;
    end
  end

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Self-checking bench for calc_key_ctrl: directed scenarios plus random key
// streams against a string-level reference model and a result scoreboard.
module tb_calc_key_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned RES_W   = 24;
  localparam longint      MASK    = 64'hFFFFFF;

  logic clk_in = 1'b0;
  logic sys_rst, btn_up, btn_down, btn_left, btn_right, btn_ok;
  logic [3:0] cursor_x, cursor_y;
  logic [MAX_LEN*8-1:0] disp_str_flat;
  logic [RES_W-1:0] result;
  logic calc_done, busy;

  calc_key_ctrl #(.MAX_LEN(MAX_LEN), .RES_W(RES_W)) dut (
    .clk_in(clk_in), .sys_rst(sys_rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_ok(btn_ok),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .disp_str_flat(disp_str_flat),
    .result(result), .calc_done(calc_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model state
  int mx, my;
  byte unsigned mstr[$];
  bit mdone;
  logic [RES_W-1:0] mres;
  string km[4];

  typedef struct { logic [RES_W-1:0] res; int due; } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [MAX_LEN*8-1:0] act,
                     input logic [MAX_LEN*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [MAX_LEN*8-1:0] exp_flat();
    logic [MAX_LEN*8-1:0] f;
    for (int k = 0; k < MAX_LEN; k++)
      f[k*8 +: 8] = (k < mstr.size()) ? mstr[k] : 8'h20;
    return f;
  endfunction

  function automatic longint do_op(input byte unsigned o, input longint a, input longint b);
    if (o == "-") return (a - b) & MASK;
    if (o == "*") return (a * b) & MASK;
    return (a + b) & MASK;
  endfunction

  // Strict left-to-right evaluation of the model string
  function automatic logic [RES_W-1:0] ref_eval();
    longint acc = 0, num = 0;
    byte unsigned op = "+";
    foreach (mstr[i]) begin
      if (mstr[i] >= "0" && mstr[i] <= "9") num = (num * 10 + longint'(mstr[i] - "0")) & MASK;
      else begin
        acc = do_op(op, acc, num);
        op = mstr[i];
        num = 0;
      end
    end
    return RES_W'(do_op(op, acc, num));
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mstr.delete(); mdone = 0; mres = '0; sbq.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_cx"}, cursor_x, mx);
    chk({tag, "_cy"}, cursor_y, my);
    chk({tag, "_str"}, disp_str_flat, exp_flat());
    chk({tag, "_done"}, calc_done, mdone);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, result, mres);
  endtask

  task automatic do_reset_async();
    #3 sys_rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk_in);
    sys_rst = 1'b0;
  endtask

  task automatic nav(input bit u, input bit d, input bit l, input bit r);
    @(negedge clk_in);
    {btn_up, btn_down, btn_left, btn_right} = {u, d, l, r};
    @(negedge clk_in);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    if (u) my = (my + 3) % 4;
    else if (d) my = (my + 1) % 4;
    else if (l) mx = (mx + 3) % 4;
    else if (r) mx = (mx + 1) % 4;
    chk("nav_x", cursor_x, mx);
    chk("nav_y", cursor_y, my);
  endtask

  task automatic key(input byte unsigned ch, input bit abort_rst = 1'b0);
    int tr = 0, tc = 0, acc_cyc, n, w;
    bit dir;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (km[r][c] == ch) begin tr = r; tc = c; end
    dir = 1'($urandom_range(0, 1));
    while (mx != tc) nav(0, 0, dir, !dir);
    dir = 1'($urandom_range(0, 1));
    while (my != tr) nav(dir, !dir, 0, 0);
    @(negedge clk_in);
    btn_ok = 1'b1;
    if ($urandom_range(0, 2) == 0) {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
    acc_cyc = cyc + 1;
    @(negedge clk_in);
    {btn_ok, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    if (ch >= "0" && ch <= "9") begin
      if (mdone) begin mstr.delete(); mdone = 0; end
      if (mstr.size() < MAX_LEN) mstr.push_back(ch);
    end else if (ch == "+" || ch == "-" || ch == "*") begin
      mdone = 0;
      if (mstr.size() < MAX_LEN) mstr.push_back(ch);
    end else if (ch == "C") begin
      mstr.delete(); mres = '0; mdone = 0;
    end else if (ch == "B") begin
      if (mstr.size() > 0) begin void'(mstr.pop_back()); mdone = 0; end
    end else if (ch == "=") begin
      mdone = 0;
      n = mstr.size();
      sbq.push_back('{ref_eval(), acc_cyc + n + 1});
      chk("eq_busy", busy, 1);
      if (abort_rst) begin
        do_reset_async();
        return;
      end
      // Buttons hammered during evaluation must be ignored
      for (int k = 0; k < n; k++) begin
        {btn_up, btn_down, btn_left, btn_right, btn_ok} = 5'($urandom);
        @(negedge clk_in);
      end
      {btn_up, btn_down, btn_left, btn_right, btn_ok} = 5'b0;
      w = 0;
      while (!calc_done && w < 40) begin @(negedge clk_in); w++; end
      if (w >= 40) chk("calc_done_timeout", calc_done, 1);
      mdone = 1;
      mres = ref_eval();
    end
    check_outputs("key");
  endtask

  task automatic keys(input string s);
    string t = s;
    for (int i = 0; i < t.len(); i++) key(t[i]);
  endtask

  // Scoreboard monitor: pops on each rising calc_done
  bit prev_done = 1'b0;
  always @(negedge clk_in) begin
    if (sys_rst) prev_done = 1'b0;
    else begin
      if (calc_done && !prev_done) begin
        if (sbq.size() == 0) chk("sb_unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_latency", cyc, e.due);
        end
      end
      prev_done = calc_done;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    string alpha;
    string a;
    km[0] = "123+"; km[1] = "456-"; km[2] = "789*"; km[3] = "C0=B";
    sys_rst = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_ok} = 5'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check_outputs("reset");
    sys_rst = 1'b0;
    @(negedge clk_in);
    check_outputs("post_reset");

    repeat (4) nav(0, 0, 0, 1);
    nav(1, 0, 0, 0);
    chk("wrap_up_y", cursor_y, 3);
    nav(1, 1, 1, 1);
    nav(0, 1, 1, 1);
    nav(0, 0, 1, 1);

    keys("12+3=");
    chk("res_12p3", result, 15);
    chk("str_12p3", disp_str_flat[31:0], 32'h332B3231);
    keys("C9-10=");
    chk("res_wrap", result, 24'hFFFFFF);
    keys("C2+3*4=");
    chk("res_20", result, 20);
    keys("7");
    chk("done_then_7", disp_str_flat[7:0], 8'h37);
    keys("C");
    repeat (17) key("5");
    chk("len16_last", disp_str_flat[127:120], 8'h35);
    keys("B");
    chk("bs_slot15", disp_str_flat[127:120], 8'h20);
    keys("CB");
    keys("*5=");
    chk("res_lead_op", result, 0);
    keys("=");
    keys("C123456");
    key("=", 1'b1);
    keys("4*6=");
    chk("res_after_abort", result, 24);

    alpha = "0123456789+-*CB=";
    for (int i = 0; i < 250; i++) begin
      int p = $urandom_range(0, 99);
      if (p < 55) key(alpha[$urandom_range(0, 9)]);
      else if (p < 80) key(alpha[$urandom_range(10, 12)]);
      else if (p < 83) key("C");
      else if (p < 88) key("B");
      else if (p < 90) nav(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else key("=");
    end
    a = "9999999*9999999=";
    keys("C");
    keys(a);

    repeat (3) @(negedge clk_in);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
